// File: rtl/result_tx_scheduler.sv
// result_tx_scheduler: round-robin arbiter that turns finished solver results into
// ASCII frames (<tag> <decimal digits> <LF>) on the shared SPI master transmit path.
module result_tx_scheduler #(
    parameter int unsigned REQ_COUNT    = 3,
    parameter int unsigned VALUE_WIDTH  = 32,
    parameter int unsigned DIGITS       = 10,
    parameter int unsigned SLAVE_COUNT  = 3,
    parameter int unsigned RESULT_SLAVE = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [REQ_COUNT*VALUE_WIDTH-1:0] req_value,
    input  logic [REQ_COUNT-1:0]             req_valid,
    output logic [REQ_COUNT-1:0]             req_ack,
    input  logic                             spi_ready,
    output logic [7:0]                       tx_byte,
    output logic                             tx_byte_valid,
    output logic [SLAVE_COUNT-1:0]           ss_in,
    output logic                             busy
);

    localparam int unsigned IDX_W = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
    localparam int unsigned CNT_W = $clog2(VALUE_WIDTH + 1);
    localparam int unsigned DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned BCD_W = 4 * DIGITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_CONVERT,
        S_SEND,
        S_WAIT_LO,
        S_WAIT_HI
    } state_t;

    // Which part of the frame the next SEND emits.
    typedef enum logic [1:0] {
        PH_TAG,
        PH_DIG,
        PH_LF,
        PH_DONE
    } phase_t;

    state_t                   state_q, state_d;
    phase_t                   phase_q, phase_d;
    logic [IDX_W-1:0]         ptr_q, ptr_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [VALUE_WIDTH-1:0]   val_q, val_d;
    logic [BCD_W-1:0]         bcd_q, bcd_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DIG_W-1:0]         dig_q, dig_d;
    logic [REQ_COUNT-1:0]     req_ack_q, req_ack_d;
    logic [7:0]               tx_byte_q, tx_byte_d;
    logic                     tx_valid_q, tx_valid_d;
    logic [SLAVE_COUNT-1:0]   ss_in_q, ss_in_d;
    logic                     busy_q, busy_d;

    logic                     grant_found;
    logic [IDX_W-1:0]         grant_idx;
    logic [IDX_W:0]           scan_pos;
    logic [BCD_W-1:0]         bcd_adj;
    logic [BCD_W-1:0]         bcd_step;
    logic [DIG_W-1:0]         msd;

    // Round-robin pick: first asserted request scanning upward from ptr with wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_pos    = '0;
        for (int unsigned k = 0; k < REQ_COUNT; k++) begin
            scan_pos = {1'b0, ptr_q} + (IDX_W + 1)'(k);
            if (scan_pos >= (IDX_W + 1)'(REQ_COUNT)) begin
                scan_pos = scan_pos - (IDX_W + 1)'(REQ_COUNT);
            end
            if (!grant_found && req_valid[scan_pos[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_pos[IDX_W-1:0];
            end
        end
    end

    // One double-dabble step, plus the most significant nonzero digit of its result.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned n = 0; n < DIGITS; n++) begin
            if (bcd_q[4*n +: 4] >= 4'd5) begin
                bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
            end
        end
        // The top BCD bit can never be set given the digit budget, so it is shifted out.
        bcd_step = BCD_W'({bcd_adj, val_q[VALUE_WIDTH-1]});
        msd = '0;
        for (int unsigned n = 0; n < DIGITS; n++) begin
            if (bcd_step[4*n +: 4] != 4'h0) begin
                msd = DIG_W'(n);
            end
        end
    end

    // Frame sequencer: next-state and next-output computation.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        val_d      = val_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        dig_d      = dig_q;
        req_ack_d  = '0;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = 1'b0;
        ss_in_d    = ss_in_q;
        busy_d     = busy_q;

        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    state_d              = S_GRANT;
                    idx_d                = grant_idx;
                    val_d                = req_value[grant_idx*VALUE_WIDTH +: VALUE_WIDTH];
                    req_ack_d[grant_idx] = 1'b1;
                    busy_d               = 1'b1;
                    ss_in_d              = '0;
                    ss_in_d[RESULT_SLAVE] = 1'b1;
                    if (grant_idx == IDX_W'(REQ_COUNT - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = grant_idx + IDX_W'(1);
                    end
                end
            end
            S_GRANT: begin
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = S_CONVERT;
            end
            S_CONVERT: begin
                bcd_d = bcd_step;
                val_d = val_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(VALUE_WIDTH - 1)) begin
                    state_d = S_SEND;
                    phase_d = PH_TAG;
                    dig_d   = msd;
                end
            end
            S_SEND: begin
                if (spi_ready) begin
                    tx_valid_d = 1'b1;
                    state_d    = S_WAIT_LO;
                    case (phase_q)
                        PH_TAG: begin
                            tx_byte_d = 8'h41 + 8'(idx_q);
                            phase_d   = PH_DIG;
                        end
                        PH_DIG: begin
                            tx_byte_d = 8'h30 + {4'h0, bcd_q[dig_q*4 +: 4]};
                            if (dig_q == '0) begin
                                phase_d = PH_LF;
                            end else begin
                                dig_d = dig_q - DIG_W'(1);
                            end
                        end
                        PH_LF: begin
                            tx_byte_d = 8'h0A;
                            phase_d   = PH_DONE;
                        end
                        default: begin
                            tx_valid_d = 1'b0;
                            state_d    = S_IDLE;
                        end
                    endcase
                end
            end
            S_WAIT_LO: begin
                if (!spi_ready) begin
                    state_d = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (spi_ready) begin
                    if (phase_q == PH_DONE) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        ss_in_d = '0;
                    end else begin
                        state_d = S_SEND;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            phase_q    <= PH_TAG;
            ptr_q      <= '0;
            idx_q      <= '0;
            val_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            dig_q      <= '0;
            req_ack_q  <= '0;
            tx_byte_q  <= '0;
            tx_valid_q <= 1'b0;
            ss_in_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            val_q      <= val_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            dig_q      <= dig_d;
            req_ack_q  <= req_ack_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            ss_in_q    <= ss_in_d;
            busy_q     <= busy_d;
        end
    end

    assign req_ack       = req_ack_q;
    assign tx_byte       = tx_byte_q;
    assign tx_byte_valid = tx_valid_q;
    assign ss_in         = ss_in_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_result_tx_scheduler.sv
// Bench for result_tx_scheduler: a frame/arbitration model plus directed scenarios.
module tb_result_tx_scheduler;

    logic        clk;
    logic        reset;
    logic [95:0] req_value;
    logic [2:0]  req_valid;
    logic [2:0]  req_ack;
    logic        spi_ready;
    logic [7:0]  tx_byte;
    logic        tx_byte_valid;
    logic [2:0]  ss_in;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_log[$];
    int         ack_log[$];
    int         ptr_m = 0;
    int         cyc = 0;
    int         ack_cyc = 0;
    bit         first_pending = 0;
    bit         lat_en = 1;
    logic [2:0] rv_prev = '0;
    logic       rdy_prev = 1'b1;
    bit         hold_ready = 0;
    int         rdy_cnt = 0;
    logic [2:0] last_ack = '0;
    logic       last_tv = 1'b0;

    result_tx_scheduler #(
        .REQ_COUNT   (3),
        .VALUE_WIDTH (32),
        .DIGITS      (10),
        .SLAVE_COUNT (3),
        .RESULT_SLAVE(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_value    (req_value),
        .req_valid    (req_valid),
        .req_ack      (req_ack),
        .spi_ready    (spi_ready),
        .tx_byte      (tx_byte),
        .tx_byte_valid(tx_byte_valid),
        .ss_in        (ss_in),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: predicts each grant from the request levels seen at the decision edge
    // and the RR pointer, then expects tag + decimal text + LF for that value.
    always @(negedge clk) begin
        int p;
        string s;
        logic [31:0] v;
        cyc++;
        if (!reset) begin
            chk("reset_outputs", {req_ack, tx_byte, tx_byte_valid, ss_in, busy}, 64'd0);
            exp_q.delete();
            ptr_m = 0;
            first_pending = 0;
        end else begin
            if (req_ack != 3'b000) begin
                p = -1;
                for (int k = 0; k < 3; k++)
                    if (p < 0 && rv_prev[(ptr_m + k) % 3]) p = (ptr_m + k) % 3;
                chk("grant_index", {61'd0, req_ack}, (p < 0) ? 64'd0 : (64'd1 << p));
                chk("busy_at_grant", {63'd0, busy}, 64'd1);
                for (int i = 0; i < 3; i++) if (req_ack[i]) ack_log.push_back(i);
                if (p >= 0) begin
                    v = req_value[p*32 +: 32];
                    exp_q.push_back(8'h41 + 8'(p));
                    s = $sformatf("%0d", v);
                    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
                    exp_q.push_back(8'h0A);
                    ptr_m = (p + 1) % 3;
                    ack_cyc = cyc;
                    first_pending = 1;
                end
            end
            if (tx_byte_valid) begin
                rx_log.push_back(tx_byte);
                chk("strobe_needs_ready", {63'd0, rdy_prev}, 64'd1);
                if (exp_q.size() == 0) chk("extra_byte_queue", exp_q.size(), 64'd1);
                else chk("tx_byte", {56'd0, tx_byte}, {56'd0, exp_q.pop_front()});
                if (first_pending) begin
                    if (lat_en) chk("first_byte_latency", cyc - ack_cyc, 64'd34);
                    first_pending = 0;
                end
            end
            if (busy) begin
                chk("ss_in_busy", {61'd0, ss_in}, 64'd4);
            end else begin
                chk("ss_in_idle", {61'd0, ss_in}, 64'd0);
                chk("frame_complete_at_idle", exp_q.size(), 64'd0);
            end
        end
        rv_prev  = req_valid;
        rdy_prev = spi_ready;
    end

    // One clock of stimulus: requesters drop on ack, a simple SPI master responds.
    task automatic tick();
        @(posedge clk);
        #1;
        last_ack  = req_ack;
        last_tv   = tx_byte_valid;
        req_valid = req_valid & ~req_ack;
        if (hold_ready) spi_ready = 1'b0;
        else if (rdy_cnt > 0) begin
            rdy_cnt--;
            if (rdy_cnt == 0) spi_ready = 1'b1;
        end else if (tx_byte_valid) begin
            spi_ready = 1'b0;
            rdy_cnt   = 2;
        end else spi_ready = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int quiet = 0;
        for (int i = 0; i < 3000 && quiet < 3; i++) begin
            tick();
            if (!busy && req_valid == 3'b000) quiet++;
            else quiet = 0;
        end
        chk({name, "_completes"}, quiet, 64'd3);
    endtask

    task automatic wait_ack(input string name);
        int got = 0;
        for (int i = 0; i < 200 && got == 0; i++) begin
            tick();
            if (last_ack != 3'b000) got = 1;
        end
        chk({name, "_ack_seen"}, got, 64'd1);
    endtask

    task automatic wait_strobes(input string name, input int n);
        int seen = 0;
        for (int i = 0; i < 500 && seen < n; i++) begin
            tick();
            if (last_tv) seen++;
        end
        chk({name, "_strobes_seen"}, seen, n);
    endtask

    task automatic check_rx(input string name, input int b, input int e, input string s);
        chk({name, "_len"}, e - b, s.len());
        for (int i = 0; i < s.len() && b + i < e; i++)
            chk({name, "_byte"}, {56'd0, rx_log[b+i]}, {56'd0, s[i]});
    endtask

    task automatic check_acks(input string name, input int b, input string s);
        chk({name, "_count"}, ack_log.size() - b, s.len());
        for (int i = 0; i < s.len() && b + i < ack_log.size(); i++)
            chk({name, "_order"}, ack_log[b+i], int'(s[i]) - 48);
    endtask

    initial begin
        int rb, ab, rb2, ab2, nstb;
        reset     = 1'b0;
        req_valid = '0;
        req_value = '0;
        spi_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // T1: single request on bit1, value 1234
        rb = rx_log.size(); ab = ack_log.size();
        req_value[32 +: 32] = 32'd1234;
        req_valid = 3'b010;
        wait_done("t1");
        check_rx("t1_frame", rb, rx_log.size(), "B1234\n");
        check_acks("t1_acks", ab, "1");

        // T2: zero and all-ones values
        rb = rx_log.size();
        req_value[0 +: 32] = 32'd0;
        req_valid = 3'b001;
        wait_done("t2a");
        check_rx("t2_zero", rb, rx_log.size(), "A0\n");
        rb = rx_log.size();
        req_value[0 +: 32] = 32'hFFFF_FFFF;
        req_valid = 3'b001;
        wait_done("t2b");
        check_rx("t2_max", rb, rx_log.size(), "A4294967295\n");

        // T3: bring ptr to 0, then simultaneous 0 and 2, then rotation past a re-raised req0
        req_value[64 +: 32] = 32'd7;
        req_valid = 3'b100;
        wait_done("t3_prep");
        rb = rx_log.size(); ab = ack_log.size();
        req_value[0 +: 32]  = 32'd5;
        req_value[64 +: 32] = 32'd300;
        req_valid = 3'b101;
        wait_done("t3a");
        check_acks("t3a_acks", ab, "02");
        check_rx("t3a_frames", rb, rx_log.size(), "A5\nC300\n");
        rb = rx_log.size(); ab = ack_log.size();
        req_value[32 +: 32] = 32'd99;
        req_valid = 3'b001;
        wait_ack("t3b");
        repeat (3) tick();
        req_valid = req_valid | 3'b011;
        wait_done("t3b");
        check_acks("t3b_acks", ab, "010");
        check_rx("t3b_frames", rb, rx_log.size(), "A5\nB99\nA5\n");

        // T4: spi_ready held low across the whole SEND window
        rb = rx_log.size();
        req_value[32 +: 32] = 32'd42;
        req_valid = 3'b010;
        wait_ack("t4");
        hold_ready = 1;
        lat_en = 0;
        nstb = 0;
        repeat (90) begin
            tick();
            if (last_tv) nstb++;
        end
        chk("t4_no_strobe_while_held", nstb, 64'd0);
        hold_ready = 0;
        wait_done("t4");
        lat_en = 1;
        check_rx("t4_frame", rb, rx_log.size(), "B42\n");

        // T5: reset mid-digit with two requests pending behind the active frame
        rb = rx_log.size();
        req_value[0 +: 32]  = 32'd11;
        req_value[32 +: 32] = 32'd1234567;
        req_value[64 +: 32] = 32'd22;
        req_valid = 3'b010;
        wait_ack("t5");
        repeat (2) tick();
        req_valid = req_valid | 3'b101;
        wait_strobes("t5", 2);
        tick();
        #2 reset = 1'b0;
        #1 chk("t5_async_clear", {req_ack, tx_byte, tx_byte_valid, ss_in, busy}, 64'd0);
        tick();
        tick();
        reset = 1'b1;
        rb2 = rx_log.size(); ab2 = ack_log.size();
        check_rx("t5_abandoned", rb, rb2, "B1");
        wait_done("t5");
        check_acks("t5_acks_after_reset", ab2, "02");
        check_rx("t5_frames", rb2, rx_log.size(), "A11\nC22\n");

        // T6: one-cycle request pulse while busy is never served
        rb = rx_log.size(); ab = ack_log.size();
        req_value[64 +: 32] = 32'd5;
        req_valid = 3'b100;
        wait_ack("t6");
        repeat (2) tick();
        req_valid[0] = 1'b1;
        tick();
        req_valid[0] = 1'b0;
        wait_done("t6");
        check_acks("t6_acks", ab, "2");
        check_rx("t6_frame", rb, rx_log.size(), "C5\n");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
